// File: rtl/bank_cache_ctrl_pkg.sv
// Shared types and constants for the 4-bank tile cache controller.
// Imported by the tag matcher and the controller top.
package bank_cache_ctrl_pkg;

  localparam int TAG_W     = 9;
  localparam int NUM_BANKS = 4;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [1:0]       bank_t;
  typedef logic [NUM_BANKS-1:0] sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WB_REQ,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_RESP
  } state_e;

  function automatic sel_t onehot(bank_t b);
    return sel_t'(1) << b;
  endfunction

endpackage

// File: rtl/bank_cache_ctrl_match.sv
// Valid-gated 4-way tag compare.
// Produces a one-hot match vector and an any-hit flag.
module bank_tag_match
  import bank_cache_ctrl_pkg::*;
(
  input  logic [NUM_BANKS-1:0][TAG_W-1:0] tags,
  input  logic [NUM_BANKS-1:0]            valid,
  input  tag_t                            tag,
  output sel_t                            match,
  output logic                            any_hit
);

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      match[i] = valid[i] && (tags[i] == tag);
    end
  end

  assign any_hit = |match;

endmodule

// File: rtl/bank_cache_ctrl.sv
// Sequencing controller for the rasterizer 4-bank tile cache:
// tag lookup, victim choice, writeback and fill.
module bank_cache_ctrl
  import bank_cache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  tag_t        req_tag,
  input  logic        req_write,
  output logic        resp_valid,
  output sel_t        resp_select,
  output logic        resp_hit,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output tag_t        mem_req_tag,
  output bank_t       mem_req_bank,
  input  logic        mem_done
);

  state_e state_q, state_d;

  logic [NUM_BANKS-1:0][TAG_W-1:0] tags_q;
  sel_t  valid_q, dirty_q;
  bank_t ptr_q;
  tag_t  rtag_q;
  logic  rwrite_q;
  bank_t bank_q;
  logic  from_ptr_q;
  sel_t  sel_q;
  logic  hit_q;
  logic  mwrite_q;
  tag_t  mtag_q;
  bank_t mbank_q;

  sel_t  match;
  logic  any_hit;
  bank_t hit_idx;
  bank_t vict;
  logic  vict_ptr;

  bank_tag_match u_match (
    .tags    (tags_q),
    .valid   (valid_q),
    .tag     (rtag_q),
    .match   (match),
    .any_hit (any_hit)
  );

  always_comb begin
    hit_idx = '0;
    unique case (1'b1)
      match[0]: hit_idx = 2'd0;
      match[1]: hit_idx = 2'd1;
      match[2]: hit_idx = 2'd2;
      match[3]: hit_idx = 2'd3;
      default:  hit_idx = '0;
    endcase
  end

  // Lowest invalid bank wins; round-robin pointer only once all are valid.
  always_comb begin
    vict     = ptr_q;
    vict_ptr = 1'b1;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        vict     = bank_t'(i);
        vict_ptr = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (req_valid) state_d = S_COMPARE;
      S_COMPARE:
        if (any_hit)            state_d = S_RESP;
        else if (dirty_q[vict]) state_d = S_WB_REQ;
        else                    state_d = S_FILL_REQ;
      S_WB_REQ:
        if (mem_req_ready) state_d = S_WB_WAIT;
      S_WB_WAIT:
        if (mem_done) state_d = S_FILL_REQ;
      S_FILL_REQ:
        if (mem_req_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT:
        if (mem_done) state_d = S_RESP;
      S_RESP:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q     <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      ptr_q      <= '0;
      rtag_q     <= '0;
      rwrite_q   <= 1'b0;
      bank_q     <= '0;
      from_ptr_q <= 1'b0;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      mwrite_q   <= 1'b0;
      mtag_q     <= '0;
      mbank_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            rtag_q   <= req_tag;
            rwrite_q <= req_write;
          end
        end
        S_COMPARE: begin
          if (any_hit) begin
            bank_q <= hit_idx;
            sel_q  <= match;
            hit_q  <= 1'b1;
          end else begin
            bank_q     <= vict;
            from_ptr_q <= vict_ptr;
            mbank_q    <= vict;
            mwrite_q   <= dirty_q[vict];
            mtag_q     <= dirty_q[vict] ? tags_q[vict] : rtag_q;
          end
        end
        S_WB_WAIT: begin
          if (mem_done) begin
            dirty_q[bank_q] <= 1'b0;
            mwrite_q        <= 1'b0;
            mtag_q          <= rtag_q;
          end
        end
        S_FILL_WAIT: begin
          if (mem_done) begin
            tags_q[bank_q]  <= rtag_q;
            valid_q[bank_q] <= 1'b1;
            dirty_q[bank_q] <= 1'b0;
            sel_q           <= onehot(bank_q);
            hit_q           <= 1'b0;
            if (from_ptr_q) ptr_q <= ptr_q + 2'd1;
          end
        end
        S_RESP: begin
          if (rwrite_q) dirty_q[bank_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_select   = sel_q;
  assign resp_hit      = hit_q;
  assign mem_req_valid = (state_q == S_WB_REQ) ||
                         (state_q == S_FILL_REQ);
  assign mem_req_write = mwrite_q;
  assign mem_req_tag   = mtag_q;
  assign mem_req_bank  = mbank_q;

endmodule

// File: tb/tb_bank_cache_ctrl.sv
// Self-checking bench for bank_cache_ctrl against a
// behavioural cache model.
module tb_bank_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [8:0] req_tag = '0;
  logic       req_write = 1'b0;
  logic       resp_valid;
  logic [3:0] resp_select;
  logic       resp_hit;
  logic       mem_req_valid;
  logic       mem_req_ready = 1'b0;
  logic       mem_req_write;
  logic [8:0] mem_req_tag;
  logic [1:0] mem_req_bank;
  logic       mem_done = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [8:0] m_tag [4];
  bit         m_valid [4];
  bit         m_dirty [4];
  int         m_ptr;

  logic [3:0] last_sel;
  logic       last_hit;
  int         last_lat;
  int         last_ntx;
  bit         tx_w [4];
  logic [8:0] tx_t [4];
  logic [1:0] tx_b [4];

  bank_cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tag       (req_tag),
    .req_write     (req_write),
    .resp_valid    (resp_valid),
    .resp_select   (resp_select),
    .resp_hit      (resp_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_tag   (mem_req_tag),
    .mem_req_bank  (mem_req_bank),
    .mem_done      (mem_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0;
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_ptr = 0;
  endtask

  // Drive one request, serve memory, compare against the model.
  task automatic do_request(input logic [8:0] tag, input bit wr,
                            input int stall, input bit spur);
    int e_bank;
    bit e_hit, e_wb, use_ptr;
    logic [8:0] e_wb_tag;
    int e_ntx;
    bit got;
    int cyc, phase, dly, wcnt;
    logic       cur_w;
    logic [8:0] cur_t;
    logic [1:0] cur_b;
    logic [3:0] e_sel;

    e_bank = -1;
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_tag[i] == tag) e_bank = i;
    e_hit = (e_bank >= 0);
    e_wb = 0;
    use_ptr = 0;
    e_wb_tag = '0;
    if (!e_hit) begin
      for (int i = 3; i >= 0; i--)
        if (!m_valid[i]) e_bank = i;
      if (e_bank < 0) begin
        e_bank = m_ptr;
        use_ptr = 1;
      end
      e_wb = m_dirty[e_bank];
      e_wb_tag = m_tag[e_bank];
      m_tag[e_bank] = tag;
      m_valid[e_bank] = 1;
      m_dirty[e_bank] = 0;
      if (use_ptr) m_ptr = (m_ptr + 1) % 4;
    end
    if (wr) m_dirty[e_bank] = 1;
    e_ntx = e_hit ? 0 : (e_wb ? 2 : 1);
    e_sel = 4'(1 << e_bank);

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_tag = tag;
    req_write = wr;
    @(posedge clk);
    #1 req_valid = 1'b0;

    got = 0; cyc = 0; phase = 0; dly = 0; wcnt = 0;
    last_ntx = 0;
    cur_w = 0; cur_t = '0; cur_b = '0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_req_ready = 1'b0;
      mem_done = 1'b0;
      if (resp_valid) begin
        got = 1;
        last_sel = resp_select;
        last_hit = resp_hit;
        last_lat = cyc;
      end else if (phase == 0 && mem_req_valid) begin
        if (wcnt == 0) begin
          cur_w = mem_req_write;
          cur_t = mem_req_tag;
          cur_b = mem_req_bank;
        end else begin
          checks++;
          if (mem_req_write !== cur_w || mem_req_tag !== cur_t ||
              mem_req_bank !== cur_b || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mem_req_stable: got w%b t%h b%0d rdy%b want w%b t%h b%0d rdy0",
                     mem_req_write, mem_req_tag, mem_req_bank,
                     req_ready, cur_w, cur_t, cur_b);
          end
        end
        if (wcnt < stall) begin
          wcnt++;
          mem_done = spur;
        end else begin
          mem_req_ready = 1'b1;
          mem_done = spur;
          if (last_ntx < 4) begin
            tx_w[last_ntx] = cur_w;
            tx_t[last_ntx] = cur_t;
            tx_b[last_ntx] = cur_b;
          end
          last_ntx++;
          phase = 1;
          dly = $urandom_range(0, 3);
        end
      end else if (phase == 1) begin
        if (dly == 0) begin
          mem_done = 1'b1;
          phase = 0;
          wcnt = 0;
        end else begin
          dly--;
        end
      end
    end

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout: tag %h got no response want one", tag);
      return;
    end
    checks++;
    if (last_sel !== e_sel || last_hit !== e_hit) begin
      errors++;
      $display("FAIL resp: tag %h got sel %b hit %b want sel %b hit %b",
               tag, last_sel, last_hit, e_sel, e_hit);
    end
    checks++;
    if (last_ntx != e_ntx) begin
      errors++;
      $display("FAIL mem_tx_count: tag %h got %0d want %0d",
               tag, last_ntx, e_ntx);
    end else begin
      if (e_wb) begin
        checks++;
        if (tx_w[0] !== 1'b1 || tx_t[0] !== e_wb_tag ||
            tx_b[0] !== 2'(e_bank)) begin
          errors++;
          $display("FAIL writeback: got w%b t%h b%0d want w1 t%h b%0d",
                   tx_w[0], tx_t[0], tx_b[0], e_wb_tag, e_bank);
        end
      end
      if (!e_hit) begin
        checks++;
        if (tx_w[e_ntx-1] !== 1'b0 || tx_t[e_ntx-1] !== tag ||
            tx_b[e_ntx-1] !== 2'(e_bank)) begin
          errors++;
          $display("FAIL fill: got w%b t%h b%0d want w0 t%h b%0d",
                   tx_w[e_ntx-1], tx_t[e_ntx-1], tx_b[e_ntx-1],
                   tag, e_bank);
        end
      end
    end
    if (e_hit) begin
      checks++;
      if (last_lat != 2) begin
        errors++;
        $display("FAIL hit_latency: got %0d want 2", last_lat);
      end
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_select !== e_sel ||
        resp_hit !== e_hit) begin
      errors++;
      $display("FAIL resp_hold: got v%b sel %b hit %b want v0 sel %b hit %b",
               resp_valid, resp_select, resp_hit, e_sel, e_hit);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        resp_select !== 4'b0 || resp_hit !== 1'b0 ||
        mem_req_valid !== 1'b0 || mem_req_write !== 1'b0 ||
        mem_req_tag !== 9'h0 || mem_req_bank !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy%b v%b sel%b hit%b mv%b mw%b mt%h mb%0d want 1 0 0000 0 0 0 000 0",
               req_ready, resp_valid, resp_select, resp_hit,
               mem_req_valid, mem_req_write, mem_req_tag, mem_req_bank);
    end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    logic [8:0] tags [4];
    tags = '{9'h010, 9'h020, 9'h030, 9'h040};
    for (int i = 0; i < 4; i++) begin
      do_request(tags[i], 0, 0, 0);
      checks++;
      if (last_sel !== 4'(1 << i) || last_hit !== 1'b0 ||
          last_ntx != 1) begin
        errors++;
        $display("FAIL cold_miss%0d: got sel %b hit %b ntx %0d want sel %b hit 0 ntx 1",
                 i, last_sel, last_hit, last_ntx, 4'(1 << i));
      end
    end
  endtask

  task automatic test_hit();
    do_request(9'h020, 0, 0, 0);
    checks++;
    if (last_sel !== 4'b0010 || last_hit !== 1'b1 ||
        last_lat != 2 || last_ntx != 0) begin
      errors++;
      $display("FAIL hit: got sel %b hit %b lat %0d ntx %0d want 0010 1 2 0",
               last_sel, last_hit, last_lat, last_ntx);
    end
  endtask

  task automatic test_dirty_evict();
    do_request(9'h010, 1, 0, 0);
    do_request(9'h050, 0, 0, 0);
    checks++;
    if (last_ntx != 2 || tx_w[0] !== 1'b1 || tx_t[0] !== 9'h010 ||
        tx_b[0] !== 2'd0 || tx_w[1] !== 1'b0 ||
        tx_t[1] !== 9'h050 || tx_b[1] !== 2'd0 ||
        last_sel !== 4'b0001 || last_hit !== 1'b0) begin
      errors++;
      $display("FAIL dirty_evict: got ntx %0d wb w%b t%h b%0d sel %b hit %b want 2 wb w1 t010 b0 sel 0001 hit 0",
               last_ntx, tx_w[0], tx_t[0], tx_b[0], last_sel, last_hit);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] tags [4];
    logic [3:0] sels [4];
    tags = '{9'h060, 9'h070, 9'h080, 9'h090};
    sels = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      do_request(tags[i], 0, 0, 0);
      checks++;
      if (last_sel !== sels[i] || last_hit !== 1'b0) begin
        errors++;
        $display("FAIL wrap%0d: got sel %b hit %b want sel %b hit 0",
                 i, last_sel, last_hit, sels[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_request(9'h0A0, 0, 5, 1);
    checks++;
    if (last_sel !== 4'b0010 || last_hit !== 1'b0 || last_ntx != 1) begin
      errors++;
      $display("FAIL backpressure: got sel %b hit %b ntx %0d want 0010 0 1",
               last_sel, last_hit, last_ntx);
    end
  endtask

  task automatic test_random();
    logic [8:0] pool [8];
    pool = '{9'h010, 9'h020, 9'h050, 9'h060,
             9'h0A0, 9'h0B0, 9'h0C0, 9'h1F0};
    for (int n = 0; n < 40; n++) begin
      do_request(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midop();
    bit fill_acc, pend;
    fill_acc = 0;
    pend = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_tag = 9'h1FF;
    req_write = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 100 && !fill_acc; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_done = 1'b0;
      if (pend) begin
        mem_done = 1'b1;
        pend = 0;
      end else if (mem_req_valid) begin
        mem_req_ready = 1'b1;
        if (!mem_req_write) fill_acc = 1;
        else pend = 1;
      end
    end
    checks++;
    if (!fill_acc) begin
      errors++;
      $display("FAIL midop_fill_timeout: got no fill request want one");
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        resp_select !== 4'b0 || resp_hit !== 1'b0 ||
        mem_req_valid !== 1'b0 || mem_req_write !== 1'b0 ||
        mem_req_tag !== 9'h0 || mem_req_bank !== 2'd0) begin
      errors++;
      $display("FAIL midop_reset: got rdy%b v%b sel%b hit%b mv%b mw%b mt%h mb%0d want 1 0 0000 0 0 0 000 0",
               req_ready, resp_valid, resp_select, resp_hit,
               mem_req_valid, mem_req_write, mem_req_tag, mem_req_bank);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_request(9'h1FF, 0, 0, 0);
    checks++;
    if (last_hit !== 1'b0 || last_sel !== 4'b0001) begin
      errors++;
      $display("FAIL midop_remiss: got hit %b sel %b want hit 0 sel 0001",
               last_hit, last_sel);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_dirty_evict();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
